// File: rtl/lab4_pkg.sv
// Shared constants for the tile-map VGA renderer.
// 640x480@60 timing, 40x30 tile map, default palette.
package lab4_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC_W  = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC_W  = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;

  localparam int MAP_W = 40;
  localparam int MAP_H = 30;

  localparam logic [7:0] DEF_PLAYER_RGB = 8'hE0;
  localparam logic [7:0] DEF_WALL_RGB   = 8'h1C;
  localparam logic [7:0] DEF_BG_RGB     = 8'h00;

  localparam logic [5:0] PX_RST = 6'd20;
  localparam logic [4:0] PY_RST = 5'd15;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb;
  } vga_px_t;

  function automatic logic [5:0] clamp_x(input logic [5:0] x);
    return (x > 6'(MAP_W - 1)) ? 6'(MAP_W - 1) : x;
  endfunction

  function automatic logic [4:0] clamp_y(input logic [4:0] y);
    return (y > 5'(MAP_H - 1)) ? 5'(MAP_H - 1) : y;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, raster counters and sync decode.
// Sync levels are combinational here; the top registers them.
module vga_timing
  import lab4_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC_W,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC_W,
  parameter int V_BP  = V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       visible,
  output logic       hs_n,
  output logic       vs_n
);

  localparam int HT  = H_VIS + H_FP + H_SW + H_BP;
  localparam int VT  = V_VIS + V_FP + V_SW + V_BP;
  localparam int HS0 = H_VIS + H_FP;
  localparam int HS1 = HS0 + H_SW;
  localparam int VS0 = V_VIS + V_FP;
  localparam int VS1 = VS0 + V_SW;

  logic [1:0] div;
  logic       h_last;
  logic       v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= 2'd0;
    else        div <= div + 2'd1;
  end

  assign pix_en = (div == 2'd3);
  assign h_last = (hcount == 10'(HT - 1));
  assign v_last = (vcount == 10'(VT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else if (pix_en) begin
      if (h_last) begin
        hcount <= 10'd0;
        vcount <= v_last ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  assign visible = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
  assign hs_n = !((hcount >= 10'(HS0)) && (hcount < 10'(HS1)));
  assign vs_n = !((vcount >= 10'(VS0)) && (vcount < 10'(VS1)));

endmodule

// File: rtl/vga_map_render.sv
// Tile-map renderer: bordered 40x30 map with one player tile.
// Player position is sampled once per frame at the start of vblank.
module vga_map_render
  import lab4_pkg::*;
#(
  parameter int         TILE_LOG2  = 4,
  parameter logic [7:0] PLAYER_RGB = DEF_PLAYER_RGB,
  parameter logic [7:0] WALL_RGB   = DEF_WALL_RGB,
  parameter logic [7:0] BG_RGB     = DEF_BG_RGB,
  parameter int         H_FP       = H_FRONT,
  parameter int         H_SW       = H_SYNC_W,
  parameter int         H_BP       = H_BACK,
  parameter int         V_FP       = V_FRONT,
  parameter int         V_SW       = V_SYNC_W,
  parameter int         V_BP       = V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] xpos,
  input  logic [4:0] ypos,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start
);

  localparam int H_VIS = MAP_W << TILE_LOG2;
  localparam int V_VIS = MAP_H << TILE_LOG2;

  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       visible;
  logic       hs_n;
  logic       vs_n;

  vga_timing #(
    .H_VIS(H_VIS),
    .H_FP (H_FP),
    .H_SW (H_SW),
    .H_BP (H_BP),
    .V_VIS(V_VIS),
    .V_FP (V_FP),
    .V_SW (V_SW),
    .V_BP (V_BP)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .hcount (hcount),
    .vcount (vcount),
    .visible(visible),
    .hs_n   (hs_n),
    .vs_n   (vs_n)
  );

  logic [5:0] px;
  logic [4:0] py;
  logic       latch;

  assign latch = pix_en && (hcount == 10'd0) && (vcount == 10'(V_VIS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px <= PX_RST;
      py <= PY_RST;
    end else if (latch) begin
      px <= clamp_x(xpos);
      py <= clamp_y(ypos);
    end
  end

  logic [9:0] tx;
  logic [9:0] ty;
  logic       border;
  logic       is_player;
  logic       is_wall;

  assign tx = hcount >> TILE_LOG2;
  assign ty = vcount >> TILE_LOG2;
  assign border = (tx == 10'd0) || (tx == 10'(MAP_W - 1))
               || (ty == 10'd0) || (ty == 10'(MAP_H - 1));
  assign is_player = visible && (tx == {4'd0, px}) && (ty == {5'd0, py});
  assign is_wall = visible && !is_player && border;

  vga_px_t nxt;
  vga_px_t cur;

  always_comb begin
    nxt.hsync = hs_n;
    nxt.vsync = vs_n;
    nxt.rgb   = BG_RGB;
    unique case (1'b1)
      !visible:  nxt.rgb = 8'h00;
      is_player: nxt.rgb = PLAYER_RGB;
      is_wall:   nxt.rgb = WALL_RGB;
      default:   nxt.rgb = BG_RGB;
    endcase
  end

  // Registered on pix_en so sync and colour leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= '{hsync: 1'b1, vsync: 1'b1, rgb: 8'h00};
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (hcount == 10'd0) && (vcount == 10'd0);
      if (pix_en) cur <= nxt;
    end
  end

  assign hsync = cur.hsync;
  assign vsync = cur.vsync;
  assign rgb   = cur.rgb;

endmodule

// File: tb/tb_vga_map_render.sv
// Scoreboard bench: a shrunk-timing instance runs whole frames,
// a default-timing instance is checked over its first lines.
module tb_vga_map_render;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
    logic       fs;
  } exp_t;

  localparam exp_t RST_E = '{hs: 1'b1, vs: 1'b1, rgb: 8'h00, fs: 1'b0};

  localparam int A_TL = 0;
  localparam int A_HFP = 4, A_HSW = 6, A_HBP = 6;
  localparam int A_VFP = 2, A_VSW = 2, A_VBP = 3;
  localparam int A_HT = 40 + A_HFP + A_HSW + A_HBP;
  localparam int A_VT = 30 + A_VFP + A_VSW + A_VBP;
  localparam int A_FRAME_CLK = A_HT * A_VT * 4;

  localparam int B_TL = 4;
  localparam int B_HFP = 16, B_HSW = 96, B_HBP = 48;
  localparam int B_VFP = 10, B_VSW = 2, B_VBP = 33;
  localparam int B_HT = 640 + B_HFP + B_HSW + B_HBP;
  localparam int B_VT = 480 + B_VFP + B_VSW + B_VBP;

  logic       clk;
  logic       rst_n;
  logic [5:0] xpos;
  logic [4:0] ypos;
  logic       hs_a, vs_a, fs_a;
  logic       hs_b, vs_b, fs_b;
  logic [7:0] rgb_a, rgb_b;

  int n_checks = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  vga_map_render #(
    .TILE_LOG2(A_TL),
    .H_FP(A_HFP), .H_SW(A_HSW), .H_BP(A_HBP),
    .V_FP(A_VFP), .V_SW(A_VSW), .V_BP(A_VBP)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .xpos       (xpos),
    .ypos       (ypos),
    .hsync      (hs_a),
    .vsync      (vs_a),
    .rgb        (rgb_a),
    .frame_start(fs_a)
  );

  vga_map_render dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .xpos       (xpos),
    .ypos       (ypos),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .rgb        (rgb_b),
    .frame_start(fs_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected registered outputs for raster pixel index i since reset.
  function automatic exp_t pixel(input int i, input int tl,
      input int hfp, input int hsw, input int hbp,
      input int vfp, input int vsw, input int vbp,
      input int px, input int py, input bit on_pix);
    int hv, vv, ht, vt, h, v, tx, ty;
    exp_t e;
    hv = 40 * (1 << tl);
    vv = 30 * (1 << tl);
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    h = i % ht;
    v = (i / ht) % vt;
    tx = h / (1 << tl);
    ty = v / (1 << tl);
    e.hs = !(h >= hv + hfp && h < hv + hfp + hsw);
    e.vs = !(v >= vv + vfp && v < vv + vfp + vsw);
    if (h >= hv || v >= vv) e.rgb = 8'h00;
    else if (tx == px && ty == py) e.rgb = 8'hE0;
    else if (tx == 0 || tx == 39 || ty == 0 || ty == 29) e.rgb = 8'h1C;
    else e.rgb = 8'h00;
    e.fs = on_pix && h == 0 && v == 0;
    return e;
  endfunction

  exp_t qa[$];
  exp_t qb[$];
  int ka = 0, kb = 0;
  int pxa = 20, pya = 15, pxb = 20, pyb = 15;
  int cfa = 0, cva = 0, cha = 0;

  always @(posedge clk) begin
    int i, h, v;
    exp_t e;
    if (armed) begin
      e = RST_E;
      if (!rst_n) begin
        ka = 0; pxa = 20; pya = 15;
        cfa = 0; cva = 0; cha = 0;
      end else begin
        ka++;
        if (ka >= 4) begin
          i = ka / 4 - 1;
          e = pixel(i, A_TL, A_HFP, A_HSW, A_HBP, A_VFP, A_VSW, A_VBP,
                    pxa, pya, ka % 4 == 0);
          h = i % A_HT;
          v = (i / A_HT) % A_VT;
          cha = h; cva = v; cfa = i / (A_HT * A_VT);
          if (ka % 4 == 0 && h == 0 && v == 30) begin
            pxa = (xpos > 6'd39) ? 39 : int'(xpos);
            pya = (ypos > 5'd29) ? 29 : int'(ypos);
          end
        end
      end
      qa.push_back(e);
    end
  end

  always @(posedge clk) begin
    int i, h, v;
    exp_t e;
    if (armed) begin
      e = RST_E;
      if (!rst_n) begin
        kb = 0; pxb = 20; pyb = 15;
      end else begin
        kb++;
        if (kb >= 4) begin
          i = kb / 4 - 1;
          e = pixel(i, B_TL, B_HFP, B_HSW, B_HBP, B_VFP, B_VSW, B_VBP,
                    pxb, pyb, kb % 4 == 0);
          h = i % B_HT;
          v = (i / B_HT) % B_VT;
          if (kb % 4 == 0 && h == 0 && v == 480) begin
            pxb = (xpos > 6'd39) ? 39 : int'(xpos);
            pyb = (ypos > 5'd29) ? 29 : int'(ypos);
          end
        end
      end
      qb.push_back(e);
    end
  end

  int gap_a = 0;
  bit seen_a = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (armed) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL A scoreboard empty at %0t", $time);
      end else begin
        e = qa.pop_front();
        chk("A out {hs,vs,rgb,fs}", {hs_a, vs_a, rgb_a, fs_a}, e);
      end
      if (!rst_n) seen_a = 1'b0;
      gap_a++;
      if (fs_a) begin
        if (seen_a) chk("A frame period clk", gap_a, A_FRAME_CLK);
        seen_a = 1'b1;
        gap_a = 0;
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (armed) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL B scoreboard empty at %0t", $time);
      end else begin
        e = qb.pop_front();
        chk("B out {hs,vs,rgb,fs}", {hs_b, vs_b, rgb_b, fs_b}, e);
      end
    end
  end

  task automatic chk_reset_now(input string nm);
    chk({nm, " A"}, {hs_a, vs_a, rgb_a, fs_a}, RST_E);
    chk({nm, " B"}, {hs_b, vs_b, rgb_b, fs_b}, RST_E);
  endtask

  task automatic wait_pos(input int f, input int v, input int h);
    int n = 0;
    while (!(cfa == f && cva == v && cha >= h)) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        n_checks++; n_fail++;
        $display("FAIL wait_pos timeout frame %0d line %0d", f, v);
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    xpos = 6'd0;
    ypos = 5'd0;
    #2;
    rst_n = 1'b0;
    armed = 1'b1;
    #1;
    chk_reset_now("reset entry");
    repeat (3) @(negedge clk);
    xpos = 6'd5;
    ypos = 5'd7;
    rst_n = 1'b1;
    wait_pos(1, 20, 0);
    xpos = 6'd6;
    wait_pos(2, 5, 0);
    xpos = 6'd63;
    ypos = 5'd31;
    wait_pos(3, 2, 0);
    repeat (16) begin
      repeat ($urandom_range(200, 1200)) @(negedge clk);
      xpos = 6'($urandom_range(0, 63));
      ypos = 5'($urandom_range(0, 31));
    end
    wait_pos(cfa + 1, 10, 30);
    rst_n = 1'b0;
    #1;
    chk_reset_now("mid-frame reset");
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (A_FRAME_CLK + 3000) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
